// File: rtl/lfsr_pkg.sv
// Shared LFSR definition for generador_lfsr and checker_lfsr: x^8+x^6+x^5+x^4+1, Fibonacci form.
package lfsr_pkg;

  localparam int unsigned LFSR_W   = 8;
  localparam int unsigned PERIOD_W = 9;

  // Feedback taps on bits 7, 5, 4 and 3.
  localparam logic [LFSR_W-1:0] TAP = 8'hB8;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & TAP)};
  endfunction

endpackage

// File: rtl/checker_lfsr_if.sv
// Sample stream in, lock/error/period status out, between the link and checker_lfsr.
interface checker_lfsr_if #(
  parameter int unsigned CNT_W = 16
);
  import lfsr_pkg::*;

  logic                  i_valid;
  logic [LFSR_W-1:0]     i_LFSR;
  logic                  o_lock;
  logic                  o_err;
  logic [CNT_W-1:0]      o_err_count;
  logic [PERIOD_W-1:0]   o_period;
  logic                  o_period_valid;

  modport master (
    output i_valid, i_LFSR,
    input  o_lock, o_err, o_err_count, o_period, o_period_valid
  );

  modport slave (
    input  i_valid, i_LFSR,
    output o_lock, o_err, o_err_count, o_period, o_period_valid
  );

endinterface

// File: rtl/lfsr_step.sv
// One combinational LFSR advance: next_c = next(s).
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] s,
  output logic [LFSR_W-1:0] next_c
);

  assign next_c = lfsr_next(s);

endmodule

// File: rtl/checker_lfsr.sv
// Self-synchronising LFSR stream checker: locks to the sequence, counts mismatches,
// and measures the sequence period in valid samples.
module checker_lfsr
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_MATCH = 4,
  parameter int unsigned LOCK_LOSS  = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_soft_reset,
  checker_lfsr_if.slave bus
);

  localparam int unsigned MATCH_W = $clog2(LOCK_MATCH + 1);
  localparam int unsigned LOSS_W  = $clog2(LOCK_LOSS + 1);

  state_t                state_q, state_d;
  logic [LFSR_W-1:0]     pred_q, pred_d;
  logic [LFSR_W-1:0]     ref_q, ref_d;
  logic [MATCH_W-1:0]    match_q, match_d;
  logic [LOSS_W-1:0]     miss_q, miss_d;
  logic [PERIOD_W-1:0]   pcnt_q, pcnt_d;
  logic                  lock_q, lock_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic                  pv_q, pv_d;

  logic [LFSR_W-1:0]     x_c;
  logic [LFSR_W-1:0]     seed_c;
  logic [LFSR_W-1:0]     fly_c;
  logic [PERIOD_W-1:0]   pcnt_inc_c;

  assign x_c = bus.i_LFSR;

  // Seed path predicts from the received sample; flywheel path coasts on the prediction.
  lfsr_step u_seed (.s(x_c),    .next_c(seed_c));
  lfsr_step u_fly  (.s(pred_q), .next_c(fly_c));

  assign pcnt_inc_c = (pcnt_q == '1) ? pcnt_q : pcnt_q + 1'b1;

  // State and all registered outputs.
  always_ff @(posedge clk) begin
    if (!i_rst || i_soft_reset) begin
      state_q  <= SEARCH;
      pred_q   <= '0;
      ref_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      pcnt_q   <= '0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      ref_q    <= ref_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      pcnt_q   <= pcnt_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
    end
  end

  // Next-state and datapath; everything holds when no valid sample arrives.
  always_comb begin
    state_d  = state_q;
    pred_d   = pred_q;
    ref_d    = ref_q;
    match_d  = match_q;
    miss_d   = miss_q;
    pcnt_d   = pcnt_q;
    lock_d   = lock_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    period_d = period_q;
    pv_d     = 1'b0;

    if (bus.i_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (x_c != '0) begin
            pred_d  = seed_c;
            match_d = '0;
            state_d = SYNC;
          end
        end

        SYNC: begin
          if (x_c == '0) begin
            state_d = SEARCH;
          end else if (x_c == pred_q) begin
            pred_d  = seed_c;
            match_d = match_q + 1'b1;
            if (match_q == MATCH_W'(LOCK_MATCH - 1)) begin
              state_d = LOCKED;
              lock_d  = 1'b1;
              ref_d   = x_c;
              pcnt_d  = '0;
              miss_d  = '0;
            end
          end else begin
            pred_d  = seed_c;
            match_d = '0;
          end
        end

        LOCKED: begin
          pcnt_d = pcnt_inc_c;
          if (x_c == pred_q) begin
            pred_d = seed_c;
            miss_d = '0;
            if (x_c == ref_q) begin
              period_d = pcnt_inc_c;
              pv_d     = 1'b1;
              pcnt_d   = '0;
            end
          end else begin
            // Never re-seed from a bad sample while locked.
            err_d  = 1'b1;
            cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            pred_d = fly_c;
            miss_d = miss_q + 1'b1;
            if (miss_q == LOSS_W'(LOCK_LOSS - 1)) begin
              state_d = SEARCH;
              lock_d  = 1'b0;
            end
          end
        end

        default: state_d = SEARCH;
      endcase
    end
  end

  assign bus.o_lock         = lock_q;
  assign bus.o_err          = err_q;
  assign bus.o_err_count    = cnt_q;
  assign bus.o_period       = period_q;
  assign bus.o_period_valid = pv_q;

endmodule

// File: tb/tb_checker_lfsr.sv
// Directed bench for checker_lfsr: a behavioural model feeds an expected-output queue
// that is checked every cycle, plus targeted checks on lock, errors and period.
module tb_checker_lfsr;
  import lfsr_pkg::*;

  typedef struct packed {
    logic        lock;
    logic        err;
    logic [15:0] cnt;
    logic [8:0]  per;
    logic        pv;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic srst;

  always #5 clk = ~clk;

  checker_lfsr_if #(.CNT_W(16)) bus ();

  checker_lfsr #(
    .LOCK_MATCH (4),
    .LOCK_LOSS  (8),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .i_rst        (rst),
    .i_soft_reset (srst),
    .bus          (bus)
  );

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state.
  int         ms, mm, mmiss, mpc, mcnt, mper;
  logic [7:0] mp, mref;
  bit         ml, merr, mpv;

  // Generator model and observed-pulse tallies.
  logic [7:0] g;
  int         n_err, n_pv, last_per;

  function automatic logic [7:0] gen_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] x, input bit sr, input bit hr);
    obs_t e;
    if (hr || sr) begin
      ms = 0; mm = 0; mmiss = 0; mpc = 0; mcnt = 0; mper = 0;
      mp = '0; mref = '0; ml = 0; merr = 0; mpv = 0;
    end else begin
      merr = 0;
      mpv  = 0;
      if (v) begin
        case (ms)
          0: if (x != 8'h00) begin mp = gen_next(x); mm = 0; ms = 1; end
          1: begin
            if (x == 8'h00) ms = 0;
            else if (x == mp) begin
              mp = gen_next(x);
              mm = mm + 1;
              if (mm == 4) begin ms = 2; ml = 1; mref = x; mpc = 0; mmiss = 0; end
            end else begin
              mp = gen_next(x);
              mm = 0;
            end
          end
          default: begin
            mpc = (mpc == 511) ? 511 : mpc + 1;
            if (x == mp) begin
              mp    = gen_next(x);
              mmiss = 0;
              if (x == mref) begin mper = mpc; mpv = 1; mpc = 0; end
            end else begin
              merr  = 1;
              if (mcnt != 65535) mcnt = mcnt + 1;
              mp    = gen_next(mp);
              mmiss = mmiss + 1;
              if (mmiss == 8) begin ms = 0; ml = 0; end
            end
          end
        endcase
      end
    end
    e.lock = ml;
    e.err  = merr;
    e.cnt  = 16'(mcnt);
    e.per  = 9'(mper);
    e.pv   = mpv;
    exp_q.push_back(e);
  endtask

  // One clock: drive at negedge, predict, then compare just after the rising edge.
  task automatic cyc(input bit v, input logic [7:0] x, input bit sr);
    obs_t got, e;
    @(negedge clk);
    bus.i_valid = v;
    bus.i_LFSR  = x;
    srst        = sr;
    model_step(v, x, sr, !rst);
    @(posedge clk);
    #1;
    got.lock = bus.o_lock;
    got.err  = bus.o_err;
    got.cnt  = bus.o_err_count;
    got.per  = bus.o_period;
    got.pv   = bus.o_period_valid;
    e = exp_q.pop_front();
    total++;
    assert (got === e) else begin
      bad++;
      $error("FAIL scoreboard observed=%h expected=%h", got, e);
    end
    if (got.err === 1'b1) n_err++;
    if (got.pv === 1'b1) begin
      n_pv++;
      last_per = int'(got.per);
    end
  endtask

  // Generator: a valid cycle sends the current value (optionally corrupted) and advances.
  task automatic gen(input bit v, input logic [7:0] corrupt);
    if (v) begin
      cyc(1'b1, g ^ corrupt, 1'b0);
      g = gen_next(g);
    end else begin
      cyc(1'b0, 8'($urandom), 1'b0);
    end
  endtask

  initial begin
    rst         = 1'b0;
    srst        = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_LFSR  = '0;
    g           = 8'h00;
    n_err = 0; n_pv = 0; last_per = 0;

    repeat (3) cyc(1'b1, 8'h5A, 1'b0);
    chk("reset_lock", 32'(bus.o_lock), 32'd0);
    chk("reset_cnt", 32'(bus.o_err_count), 32'd0);
    chk("reset_period", 32'(bus.o_period), 32'd0);

    // Release reset; soft reset coincides with a valid sample that must be discarded.
    rst = 1'b1;
    g   = 8'h1A;
    cyc(1'b1, 8'h77, 1'b1);
    chk("srst_discard_lock", 32'(bus.o_lock), 32'd0);

    n_err = 0;
    for (int i = 0; i < 5; i++) begin
      gen(1'b1, 8'h00);
      if (i == 3) chk("lock_after_4th", 32'(bus.o_lock), 32'd0);
    end
    chk("lock_after_5th", 32'(bus.o_lock), 32'd1);
    chk("lock_cnt", 32'(bus.o_err_count), 32'd0);

    n_pv = 0;
    repeat (600) gen(1'b1, 8'h00);
    chk("period_pulses", 32'(n_pv), 32'd2);
    chk("period_value", 32'(last_per), 32'd255);
    chk("locked_no_err", 32'(n_err), 32'd0);

    gen(1'b1, 8'h01);
    chk("single_err_pulse", 32'(bus.o_err), 32'd1);
    chk("single_err_cnt", 32'(bus.o_err_count), 32'd1);
    chk("single_err_lock", 32'(bus.o_lock), 32'd1);
    gen(1'b1, 8'h00);
    chk("after_err_clean", 32'(bus.o_err), 32'd0);
    chk("after_err_lock", 32'(bus.o_lock), 32'd1);

    // Fresh statistics, relock, then lose lock with eight bad samples.
    cyc(1'b0, 8'h00, 1'b1);
    chk("srst2_cnt", 32'(bus.o_err_count), 32'd0);
    repeat (5) gen(1'b1, 8'h00);
    chk("relock_pre_loss", 32'(bus.o_lock), 32'd1);
    for (int i = 0; i < 8; i++) begin
      gen(1'b1, 8'h01);
      if (i == 6) chk("lock_after_7_bad", 32'(bus.o_lock), 32'd1);
    end
    chk("loss_cnt", 32'(bus.o_err_count), 32'd8);
    chk("loss_lock", 32'(bus.o_lock), 32'd0);
    for (int i = 0; i < 5; i++) begin
      gen(1'b1, 8'h00);
      if (i == 3) chk("relock_after_4th", 32'(bus.o_lock), 32'd0);
    end
    chk("relock_lock", 32'(bus.o_lock), 32'd1);
    chk("relock_cnt", 32'(bus.o_err_count), 32'd8);

    // Gappy valid with a stalling generator.
    n_err = 0; n_pv = 0;
    repeat (1000) gen(1'($urandom_range(0, 1)), 8'h00);
    chk("gaps_no_err", 32'(n_err), 32'd0);
    chk("gaps_period", 32'(bus.o_period), 32'd255);
    chk("gaps_pulsed", 32'(n_pv > 0), 32'd1);

    cyc(1'b0, 8'h00, 1'b1);
    chk("srst_lock", 32'(bus.o_lock), 32'd0);
    chk("srst_cnt", 32'(bus.o_err_count), 32'd0);
    chk("srst_period", 32'(bus.o_period), 32'd0);
    repeat (4) cyc(1'b1, 8'h00, 1'b0);
    chk("zero_lock", 32'(bus.o_lock), 32'd0);
    chk("zero_period", 32'(bus.o_period), 32'd0);

    // A zero during SYNC returns to SEARCH; the next seed then needs five samples.
    gen(1'b1, 8'h00);
    cyc(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      gen(1'b1, 8'h00);
      if (i == 3) chk("sync_zero_4th", 32'(bus.o_lock), 32'd0);
    end
    chk("sync_zero_relock", 32'(bus.o_lock), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/checker_lfsr.md
Name: checker_lfsr

Overview:
- Receive-side companion to generador_lfsr.
- Consumes the 8-bit pseudo-random stream, self-synchronises to it, then flags and counts sample errors.
- Measures the sequence period, so BER/link tests can close the loop in hardware.
- Sits at the far end of the link or loopback path, on the same clock as the generator.

Parameters:
- LOCK_MATCH, 4: consecutive correct predictions required to declare lock.
- LOCK_LOSS, 8: consecutive mispredictions in LOCKED that drop lock.
- CNT_W, 16: width of the error counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-low reset.
- i_soft_reset  in  1  synchronous active-high: clears state and statistics.
- i_valid  in  1  qualifies i_LFSR this cycle.
- i_LFSR  in  8  received LFSR sample.
- o_lock  out  1  checker locked to sequence.
- o_err  out  1  one-cycle pulse: a locked sample mismatched.
- o_err_count  out  CNT_W  saturating mismatch count.
- o_period  out  9  last measured period, in valid samples.
- o_period_valid  out  1  one-cycle pulse when o_period updates.

Behaviour:
- Polynomial x^8+x^6+x^5+x^4+1, Fibonacci form: next(s) = {s[6:0], s[7]^s[5]^s[4]^s[3]}. Period 255; 8'h00 is illegal.
- Priority: i_rst low > i_soft_reset > sample processing.
- Reset/soft reset: state SEARCH, all outputs 0, internal predictor/ref/counters 0.
- i_valid=0: all state and counters hold; pulse outputs deassert.
- All outputs registered: a sample captured at edge N is reflected after edge N.
- SEARCH, on valid sample x:
  - x==0: ignored.
  - Otherwise pred<=next(x), match_cnt<=0, go to SYNC.
- SYNC, on valid sample x:
  - x==0: go to SEARCH.
  - x==pred: pred<=next(x), match_cnt++. When match_cnt reaches LOCK_MATCH, go to LOCKED, o_lock<=1, ref<=x, period_cnt<=0, miss_cnt<=0.
  - x!=pred: re-seed with pred<=next(x), match_cnt<=0.
  - No errors are counted in SEARCH or SYNC.
- LOCKED, on valid sample x:
  - match: pred<=next(x), miss_cnt<=0.
  - mismatch (including x==0): o_err pulse, o_err_count+1 saturating at all-ones, pred<=next(pred) (flywheel, never re-seeds from a bad sample), miss_cnt++.
  - When miss_cnt reaches LOCK_LOSS: go to SEARCH, o_lock<=0. o_err_count is retained.
- Period measurement, in LOCKED:
  - period_cnt increments per valid sample, saturating at 511.
  - On a matched sample equal to ref: o_period<=period_cnt+1, o_period_valid pulse, period_cnt<=0.
  - Leaving LOCKED leaves o_period holding its last value.
- Lock timing, LOCK_MATCH=4: the 1st valid sample seeds; o_lock rises after the 5th consecutive correct valid sample.
- Simultaneous soft reset and valid sample: the sample is discarded.

Decomposition:
- Package lfsr_pkg holds:
  - LFSR_W=8 and TAP constant.
  - State enum {SEARCH, SYNC, LOCKED}.
  - Function lfsr_next.
- lfsr_pkg is shared with generador_lfsr so both ends use one polynomial definition.
- One combinational sub-module, lfsr_step (s -> next(s)), instantiated twice: seed path and flywheel path.

Test Plan:
- Lock: release i_rst, soft-reset the generator with seed 8'h1A, i_valid=1 continuous -> o_lock=1 after 5th sample, o_err_count=0, o_err never pulses.
- Period: stay locked 600 cycles -> o_period_valid pulses twice, o_period=255 both times.
- Single error: XOR one locked sample with 8'h01 -> exactly one o_err pulse, o_err_count=1, o_lock stays 1, next sample matches.
- Lock loss/relock: corrupt 8 consecutive samples -> o_err_count=8, o_lock falls after 8th; clean stream -> o_lock=1 again 5 samples later, count stays 8.
- Valid gaps: random i_valid (generator also stalled) for 1000 cycles -> no errors, o_period=255.
- Soft reset and zero: i_soft_reset pulse while locked -> o_lock=0, o_err_count=0, o_period=0; then 8'h00 with i_valid=1 -> stays in SEARCH, no outputs change.
